// File: rtl/wb_burst_master.sv
// Wishbone B3 incrementing-burst initiator fed by a command stream, a write-data stream and a read-data stream.
// Optional stall watchdog with err_timeout output: define WB_MASTER_TIMEOUT_EN.
module wb_burst_master #(
    parameter int dw = 32,
    parameter int aw = 26,
    parameter int bl = 5
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [aw-1:0]   cmd_addr,
    input  logic [bl-1:0]   cmd_bl,
    input  logic [dw-1:0]   wdata,
    input  logic            wdata_valid,
    output logic            wdata_ready,
    output logic [dw-1:0]   rdata,
    output logic            rdata_valid,
    output logic            busy,
`ifdef WB_MASTER_TIMEOUT_EN
    output logic            err_timeout,
`endif
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [aw-1:0]   wb_addr_o,
    output logic [dw-1:0]   wb_dat_o,
    output logic [dw/8-1:0] wb_sel_o,
    output logic [2:0]      wb_cti_o,
    input  logic            wb_ack_i,
    input  logic [dw-1:0]   wb_dat_i
);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD
    } state_t;

    localparam logic [aw-1:0] ADDR_STEP = aw'(dw / 8);
    localparam logic [bl:0]   ONE_BEAT  = (bl + 1)'(1);
    localparam logic [bl:0]   MAX_BEATS = {1'b1, {bl{1'b0}}};

    state_t        state;
    state_t        state_next;
    logic [bl:0]   remaining;
    logic          we_q;
    logic          cmd_fire;
    logic          beat_done;
    logic          last_beat;
    logic          timeout_hit;
    logic          addr_lsb_unused;

    assign addr_lsb_unused = ^cmd_addr[1:0];

    assign cmd_fire  = cmd_valid & cmd_ready;
    assign beat_done = wb_stb_o & wb_ack_i;
    assign last_beat = (remaining == ONE_BEAT);

    assign busy     = (state != IDLE);
    assign wb_cyc_o = (state != IDLE);
    assign wb_we_o  = wb_cyc_o & we_q;
    assign wb_sel_o = {(dw / 8){wb_stb_o}};
    assign wb_cti_o = wb_stb_o ? (last_beat ? 3'b111 : 3'b010) : 3'b000;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A new write beat is taken when the bus is free or the current beat is being acked mid-burst.
    always_comb begin
        state_next  = state;
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = ~wb_rst_i;
                if (cmd_valid && !wb_rst_i)
                    state_next = cmd_we ? WR : RD;
            end
            WR: begin
                wdata_ready = wdata_valid && (!wb_stb_o || (wb_ack_i && !last_beat));
                if (beat_done && last_beat)
                    state_next = IDLE;
            end
            RD: begin
                if (beat_done && last_beat)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (timeout_hit)
            state_next = IDLE;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_addr_o   <= '0;
            wb_dat_o    <= '0;
            wb_stb_o    <= 1'b0;
            we_q        <= 1'b0;
            remaining   <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            if (cmd_fire) begin
                wb_addr_o <= {cmd_addr[aw-1:2], 2'b00};
                we_q      <= cmd_we;
                remaining <= (cmd_bl == '0) ? MAX_BEATS : {1'b0, cmd_bl};
                wb_stb_o  <= ~cmd_we;
            end else begin
                if (beat_done) begin
                    remaining <= remaining - ONE_BEAT;
                    wb_addr_o <= wb_addr_o + ADDR_STEP;
                    if (state == RD) begin
                        rdata       <= wb_dat_i;
                        rdata_valid <= 1'b1;
                    end
                end
                // Reads strobe continuously; writes strobe only while a fetched beat is outstanding.
                if (wdata_ready) begin
                    wb_dat_o <= wdata;
                    wb_stb_o <= 1'b1;
                end else if (beat_done) begin
                    wb_stb_o <= (state == RD) && !last_beat;
                end
                if (timeout_hit)
                    wb_stb_o <= 1'b0;
            end
        end
    end

`ifdef WB_MASTER_TIMEOUT_EN
    logic [9:0] wd_cnt;

    // Fires on the 1023rd consecutive stalled strobe cycle, when the count would reach 1023.
    assign timeout_hit = wb_stb_o && !wb_ack_i && (wd_cnt == 10'd1022);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= timeout_hit;
            if (beat_done || timeout_hit)
                wd_cnt <= '0;
            else if (wb_stb_o)
                wd_cnt <= wd_cnt + 10'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wb_burst_master.sv
// Randomized self-checking bench for wb_burst_master against a burst-level reference model.
// Define WB_MASTER_TIMEOUT_EN to include the watchdog scenario.
module tb_wb_burst_master;

    localparam int AW   = 26;
    localparam int DW   = 32;
    localparam int BL   = 5;
    localparam int MAXB = 1 << BL;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_we;
    logic [AW-1:0]   cmd_addr;
    logic [BL-1:0]   cmd_bl;
    logic [DW-1:0]   wdata;
    logic            wdata_valid;
    logic            wdata_ready;
    logic [DW-1:0]   rdata;
    logic            rdata_valid;
    logic            busy;
    logic            err_timeout;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [AW-1:0]   wb_addr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic [2:0]      wb_cti_o;
    logic            wb_ack_i;
    logic [DW-1:0]   wb_dat_i;

    wb_burst_master #(.dw(DW), .aw(AW), .bl(BL)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_addr    (cmd_addr),
        .cmd_bl      (cmd_bl),
        .wdata       (wdata),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .busy        (busy),
`ifdef WB_MASTER_TIMEOUT_EN
        .err_timeout (err_timeout),
`endif
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_addr_o   (wb_addr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_sel_o    (wb_sel_o),
        .wb_cti_o    (wb_cti_o),
        .wb_ack_i    (wb_ack_i),
        .wb_dat_i    (wb_dat_i)
    );

`ifndef WB_MASTER_TIMEOUT_EN
    assign err_timeout = 1'b0;
`endif

    always #5 wb_clk_i = ~wb_clk_i;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected beats of the current burst and the memory image the commands imply.
    logic [31:0]   ref_mem   [logic [AW-1:0]];
    logic [31:0]   slave_mem [logic [AW-1:0]];
    logic [AW-1:0] exp_addr[$];
    logic [2:0]    exp_cti[$];
    logic [31:0]   exp_wd[$];
    logic [31:0]   exp_rd[$];
    logic [31:0]   wd_q[$];
    logic [31:0]   rd_obs[$];
    bit            exp_we;
    int            exp_n;

    int  beats_done, wd_idx, stb_cycles, gap_waits;
    int  cyc_count, last_ack_cycle, cyc_fall_cycle, first_stb_cycle, err_cycle, err_count;
    bit  fall_ready, cyc_at_err;
    int  max_delay, fixed_delay, hole_pct, gap_at, gap_len;
    int  wait_cnt, cur_delay;
    bit  never_ack, spurious_en;

    function automatic logic [31:0] fill(input logic [AW-1:0] a);
        return {6'h2A, a};
    endfunction

    function automatic int pickDelay();
        return (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, max_delay));
    endfunction

    function automatic logic [103:0] outBundle();
        return {wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
                busy, rdata_valid, rdata, cmd_ready, wdata_ready};
    endfunction

    // Slave model, write-data source and bus monitor; drives at negedge, samples 1 ns later.
    initial begin : bus
        bit gap_now;
        int gap_left;
        bit prev_cyc;
        gap_left    = 0;
        prev_cyc    = 1'b0;
        wb_ack_i    = 1'b0;
        wb_dat_i    = '0;
        wdata_valid = 1'b0;
        wdata       = '0;
        forever begin
            @(negedge wb_clk_i);
            cyc_count++;
            wb_ack_i = 1'b0;
            wb_dat_i = $urandom;
            if (wb_stb_o) begin
                if (!never_ack && wait_cnt >= cur_delay) begin
                    wb_ack_i = 1'b1;
                    if (!wb_we_o)
                        wb_dat_i = slave_mem.exists(wb_addr_o) ? slave_mem[wb_addr_o] : fill(wb_addr_o);
                end else begin
                    wait_cnt++;
                end
            end else if (spurious_en && $urandom_range(0, 3) == 0) begin
                wb_ack_i = 1'b1;
            end
            if (gap_at >= 0 && wd_idx == gap_at) begin
                gap_left = gap_len;
                gap_at   = -1;
            end
            gap_now = (gap_left > 0);
            if (gap_left > 0)
                gap_left--;
            wdata_valid = (wd_idx < wd_q.size()) && !gap_now && ($urandom_range(0, 99) >= hole_pct);
            wdata       = wdata_valid ? wd_q[wd_idx] : $urandom;
            #1;
            if (wb_stb_o) begin
                stb_cycles++;
                if (first_stb_cycle < 0)
                    first_stb_cycle = cyc_count;
                checkOutput("beat_overrun", beats_done < exp_n, 1'b1);
                if (beats_done < exp_n) begin
                    checkOutput("addr", wb_addr_o, exp_addr[beats_done]);
                    checkOutput("cti", wb_cti_o, exp_cti[beats_done]);
                    checkOutput("we_sel_cyc", {wb_we_o, wb_sel_o, wb_cyc_o}, {exp_we, 4'hF, 1'b1});
                    if (exp_we)
                        checkOutput("wdat", wb_dat_o, exp_wd[beats_done]);
                end
                if (wb_ack_i) begin
                    if (wb_we_o)
                        slave_mem[wb_addr_o] = wb_dat_o;
                    beats_done++;
                    last_ack_cycle = cyc_count;
                    wait_cnt  = 0;
                    cur_delay = pickDelay();
                end
            end else if (gap_now && busy) begin
                gap_waits++;
                checkOutput("gap_cyc", wb_cyc_o, 1'b1);
            end
            if (wdata_valid && wdata_ready)
                wd_idx++;
            if (rdata_valid)
                rd_obs.push_back(rdata);
            if (prev_cyc && !wb_cyc_o) begin
                cyc_fall_cycle = cyc_count;
                fall_ready     = cmd_ready;
            end
            prev_cyc = wb_cyc_o;
            if (err_timeout) begin
                err_count++;
                if (err_cycle < 0) begin
                    err_cycle  = cyc_count;
                    cyc_at_err = wb_cyc_o;
                end
            end
        end
    end

    // Builds the expected burst from the command rules, then presents the command until accepted.
    task automatic applyStimulus(input bit we, input logic [AW-1:0] addr, input logic [BL-1:0] blf,
                                 input bit pattern);
        int            n;
        int            guard;
        logic [AW-1:0] a;
        logic [31:0]   w;
        n = (blf == '0) ? MAXB : int'(blf);
        a = {addr[AW-1:2], 2'b00};
        exp_addr.delete(); exp_cti.delete(); exp_wd.delete(); exp_rd.delete();
        wd_q.delete(); rd_obs.delete();
        beats_done = 0; wd_idx = 0; stb_cycles = 0; gap_waits = 0;
        first_stb_cycle = -1; cyc_fall_cycle = -1; last_ack_cycle = -1; fall_ready = 1'b0;
        err_cycle = -1; err_count = 0;
        exp_we = we;
        exp_n  = n;
        for (int k = 0; k < n; k++) begin
            exp_addr.push_back(a);
            exp_cti.push_back((k == n - 1) ? 3'b111 : 3'b010);
            if (we) begin
                w = pattern ? 32'h11111111 * (k + 1) : $urandom;
                exp_wd.push_back(w);
                wd_q.push_back(w);
                ref_mem[a] = w;
            end else begin
                exp_rd.push_back(ref_mem.exists(a) ? ref_mem[a] : fill(a));
            end
            a = a + AW'(4);
        end
        wait_cnt  = 0;
        cur_delay = pickDelay();
        @(negedge wb_clk_i);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_bl    = blf;
        #2;
        guard = 0;
        while (!cmd_ready && guard < 100) begin
            @(negedge wb_clk_i);
            #2;
            guard++;
        end
        checkOutput("cmd_accept", cmd_ready, 1'b1);
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        cmd_addr  = AW'($urandom);
        cmd_bl    = BL'($urandom);
        cmd_we    = $urandom_range(0, 1);
        #2;
    endtask

    task automatic waitBurst(input string name);
        int guard;
        guard = 0;
        while (busy && guard < 3000) begin
            @(negedge wb_clk_i);
            #2;
            guard++;
        end
        checkOutput({name, "_done"}, busy, 1'b0);
        @(negedge wb_clk_i);
        #2;
    endtask

    task automatic checkBurst(input string name);
        checkOutput({name, "_beats"}, beats_done, exp_n);
        checkOutput({name, "_wd_used"}, wd_idx, exp_we ? exp_n : 0);
        checkOutput({name, "_rd_count"}, rd_obs.size(), exp_rd.size());
        for (int k = 0; k < rd_obs.size() && k < exp_rd.size(); k++)
            checkOutput({name, "_rdata"}, rd_obs[k], exp_rd[k]);
        checkOutput({name, "_cyc_fall"}, cyc_fall_cycle - last_ack_cycle, 1);
        checkOutput({name, "_ready_after"}, fall_ready, 1'b1);
    endtask

    initial begin : main
        int            guard;
        int            sel;
        logic [AW-1:0] a;
        max_delay = 0; fixed_delay = 0; hole_pct = 0; gap_at = -1; gap_len = 0;
        never_ack = 1'b0; spurious_en = 1'b0; exp_n = 0; exp_we = 1'b0;
        wb_rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_bl = '0;
        repeat (3) @(negedge wb_clk_i);
        #2;
        checkOutput("reset_outputs", outBundle(), '0);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        #2;
        checkOutput("ready_after_reset", cmd_ready, 1'b1);

        applyStimulus(1'b1, 26'h0000040, 5'd4, 1'b1);
        waitBurst("wr4");
        checkBurst("wr4");
        checkOutput("wr4_cyc_low", wb_cyc_o, 1'b0);

        applyStimulus(1'b0, 26'h0000040, 5'd4, 1'b0);
        waitBurst("rd4");
        checkBurst("rd4");

        applyStimulus(1'b0, 26'h0000043, 5'd1, 1'b0);
        waitBurst("rd1");
        checkBurst("rd1");
        checkOutput("rd1_strobes", stb_cycles, 1);

        applyStimulus(1'b1, 26'h0000100, 5'd0, 1'b0);
        waitBurst("wr32");
        checkBurst("wr32");
        checkOutput("wr32_beats", beats_done, MAXB);

        fixed_delay = 3;
        applyStimulus(1'b1, 26'h0000200, 5'd4, 1'b0);
        waitBurst("wr_wait");
        checkBurst("wr_wait");
        checkOutput("wr_wait_strobes", stb_cycles, 4 * (fixed_delay + 1));
        applyStimulus(1'b0, 26'h0000200, 5'd4, 1'b0);
        waitBurst("rd_wait");
        checkBurst("rd_wait");
        checkOutput("rd_wait_strobes", stb_cycles, 4 * (fixed_delay + 1));

        fixed_delay = 0;
        gap_at = 2; gap_len = 2;
        applyStimulus(1'b1, 26'h0000300, 5'd6, 1'b0);
        waitBurst("wr_gap");
        checkBurst("wr_gap");
        checkOutput("wr_gap_stb_low", gap_waits >= 1, 1'b1);
        gap_at = -1;

        fixed_delay = 1;
        applyStimulus(1'b0, 26'h0000100, 5'd8, 1'b0);
        guard = 0;
        while (beats_done < 2 && guard < 200) begin
            @(negedge wb_clk_i);
            #2;
            guard++;
        end
        checkOutput("rst_mid_progress", beats_done >= 2, 1'b1);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        #2;
        checkOutput("rst_mid_outputs", outBundle(), '0);
        wb_rst_i = 1'b0;
        exp_n = 0;
        @(negedge wb_clk_i);
        #2;
        checkOutput("rst_mid_ready", cmd_ready, 1'b1);

        fixed_delay = 0;
        applyStimulus(1'b1, 26'h3FFFFFC, 5'd2, 1'b0);
        waitBurst("wrap_wr");
        checkBurst("wrap_wr");
        applyStimulus(1'b0, 26'h3FFFFFE, 5'd2, 1'b0);
        waitBurst("wrap_rd");
        checkBurst("wrap_rd");

        fixed_delay = -1;
        spurious_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)
                a = 26'h3FFFF80 + AW'($urandom_range(0, 31) * 4) + AW'($urandom_range(0, 3));
            else
                a = 26'h0001000 + AW'($urandom_range(0, 63) * 4) + AW'($urandom_range(0, 3));
            max_delay = $urandom_range(0, 3);
            hole_pct  = $urandom_range(0, 40);
            applyStimulus(1'($urandom_range(0, 1)), a, BL'($urandom), 1'b0);
            waitBurst("rand");
            checkBurst("rand");
        end
        hole_pct = 0;

`ifdef WB_MASTER_TIMEOUT_EN
        never_ack   = 1'b1;
        spurious_en = 1'b0;
        applyStimulus(1'b0, 26'h0000400, 5'd4, 1'b0);
        guard = 0;
        while (err_cycle < 0 && guard < 1200) begin
            @(negedge wb_clk_i);
            #2;
            guard++;
        end
        checkOutput("timeout_fired", err_cycle >= 0, 1'b1);
        checkOutput("timeout_latency", err_cycle - first_stb_cycle, 1023);
        checkOutput("timeout_cyc", cyc_at_err, 1'b0);
        repeat (3) @(negedge wb_clk_i);
        #2;
        checkOutput("timeout_pulse", err_count, 1);
        never_ack   = 1'b0;
        fixed_delay = 0;
        applyStimulus(1'b1, 26'h0000500, 5'd3, 1'b0);
        waitBurst("after_to");
        checkBurst("after_to");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
